// File: rtl/quantum_preempt_timer_pkg.sv
// Shared definitions for the quantum preemption timer: FSM states, halt codes
// and default widths.
package quantum_preempt_timer_pkg;

    localparam int QW_DEFAULT = 16;
    localparam int AW_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_EXPIRE = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] HALT_PROC    = 2'b01;
    localparam logic [1:0] HALT_MACHINE = 2'b10;

endpackage

// File: rtl/quantum_down_counter.sv
// Loadable, enable-gated down-counter that saturates at zero and flags the
// decrement that will reach zero from one.
module quantum_down_counter #(
    parameter int QW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [QW-1:0] load_val,
    input  logic          en,
    output logic [QW-1:0] count,
    output logic          will_expire
);

    // A zero count never matches here, so a zero quantum disables expiry.
    assign will_expire = en && (count == QW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - QW'(1);
        end
    end

endmodule

// File: rtl/quantum_preempt_timer.sv
// Time-quantum preemption timer: counts retired instructions of a user process,
// requests preemption on expiry and holds the preempted PC for the OS handler.
module quantum_preempt_timer
    import quantum_preempt_timer_pkg::*;
#(
    parameter int QW = QW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          set_quantum,
    input  logic [QW-1:0] quantum_in,
    input  logic          interruption_process,
    input  logic [1:0]    halt,
    input  logic [AW-1:0] pc_in,
    input  logic          irq_ack,
    output logic          irq,
    output logic [AW-1:0] saved_pc,
    output logic [QW-1:0] remaining,
    output logic          proc_done,
    output logic          halted,
    output logic [1:0]    state
);

    state_t        state_q;
    state_t        state_d;
    logic [QW-1:0] quantum_q;
    logic [QW-1:0] load_val;
    logic          cnt_load;
    logic          cnt_clear;
    logic          cnt_en;
    logic          will_expire;
    logic          capture;
    logic          done_d;

    // Enable is derived outside the FSM block so the expiry flag does not feed back.
    assign cnt_en = (state_q == S_RUN) && tick && !interruption_process
                    && (halt != HALT_PROC) && (halt != HALT_MACHINE);

    quantum_down_counter #(.QW(QW)) u_counter (
        .clock       (clock),
        .reset       (reset),
        .clear       (cnt_clear),
        .load        (cnt_load),
        .load_val    (load_val),
        .en          (cnt_en),
        .count       (remaining),
        .will_expire (will_expire)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        load_val  = quantum_q;
        capture   = 1'b0;
        done_d    = 1'b0;
        if ((state_q != S_HALTED) && (halt == HALT_MACHINE)) begin
            state_d = S_HALTED;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (interruption_process) begin
                        state_d  = S_RUN;
                        cnt_load = 1'b1;
                        load_val = set_quantum ? quantum_in : quantum_q;
                    end
                end
                S_RUN: begin
                    if (halt == HALT_PROC) begin
                        state_d   = S_IDLE;
                        cnt_clear = 1'b1;
                        done_d    = 1'b1;
                    end else if (interruption_process) begin
                        cnt_load = 1'b1;
                    end else if (will_expire) begin
                        state_d = S_EXPIRE;
                        capture = 1'b1;
                    end
                end
                S_EXPIRE: begin
                    if (irq_ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quantum_q <= '0;
            saved_pc  <= '0;
            irq       <= 1'b0;
            halted    <= 1'b0;
            proc_done <= 1'b0;
        end else begin
            if (set_quantum && (state_q != S_HALTED)) begin
                quantum_q <= quantum_in;
            end
            if (capture) begin
                saved_pc <= pc_in;
            end
            irq       <= (state_d == S_EXPIRE);
            halted    <= (state_d == S_HALTED);
            proc_done <= done_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_quantum_preempt_timer.sv
// Self-checking bench for quantum_preempt_timer: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_quantum_preempt_timer;

    localparam int QW = 16;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic          set_quantum = 1'b0;
    logic [QW-1:0] quantum_in = '0;
    logic          interruption_process = 1'b0;
    logic [1:0]    halt = 2'b00;
    logic [AW-1:0] pc_in = '0;
    logic          irq_ack = 1'b0;
    logic          irq;
    logic [AW-1:0] saved_pc;
    logic [QW-1:0] remaining;
    logic          proc_done;
    logic          halted;
    logic [1:0]    state;

    quantum_preempt_timer #(.QW(QW), .AW(AW)) dut (
        .clock                (clock),
        .reset                (reset),
        .tick                 (tick),
        .set_quantum          (set_quantum),
        .quantum_in           (quantum_in),
        .interruption_process (interruption_process),
        .halt                 (halt),
        .pc_in                (pc_in),
        .irq_ack              (irq_ack),
        .irq                  (irq),
        .saved_pc             (saved_pc),
        .remaining            (remaining),
        .proc_done            (proc_done),
        .halted               (halted),
        .state                (state)
    );

    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: mode holds the externally visible state code.
    int unsigned   m_mode;
    int unsigned   m_q;
    int unsigned   m_rem;
    logic [AW-1:0] m_pc;
    bit            m_irq;
    bit            m_done;
    bit            m_halted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_q = 0; m_rem = 0; m_pc = '0;
        m_irq = 0; m_done = 0; m_halted = 0;
    endtask

    task automatic model_step();
        int unsigned nq;
        nq = m_q;
        m_done = 0;
        if (set_quantum && m_mode != 3) nq = int'(quantum_in);
        if (m_mode != 3 && halt == 2'b10) begin
            m_mode = 3;
        end else if (m_mode == 0) begin
            if (interruption_process) begin
                m_rem  = set_quantum ? int'(quantum_in) : m_q;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (halt == 2'b01) begin
                m_mode = 0; m_rem = 0; m_done = 1;
            end else if (interruption_process) begin
                m_rem = m_q;
            end else if (tick && m_rem == 1) begin
                m_mode = 2; m_rem = 0; m_pc = pc_in;
            end else if (tick && m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end else if (m_mode == 2) begin
            if (irq_ack) m_mode = 0;
        end
        m_q      = nq;
        m_irq    = (m_mode == 2);
        m_halted = (m_mode == 3);
    endtask

    task automatic check_all();
        check("state",     64'(state),     64'(m_mode));
        check("remaining", 64'(remaining), 64'(m_rem));
        check("irq",       64'(irq),       64'(m_irq));
        check("saved_pc",  64'(saved_pc),  64'(m_pc));
        check("proc_done", 64'(proc_done), 64'(m_done));
        check("halted",    64'(halted),    64'(m_halted));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic apply(input bit sq, input int unsigned qi, input bit ip, input bit tk,
                         input logic [1:0] h, input logic [AW-1:0] pc, input bit ack);
        set_quantum = sq; quantum_in = QW'(qi); interruption_process = ip;
        tick = tk; halt = h; pc_in = pc; irq_ack = ack;
        cycle();
    endtask

    // Assert reset away from any edge and check outputs before the next edge.
    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int unsigned stall_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int unsigned stall_rem[7] = '{3, 3, 3, 2, 1, 1, 0};
        int unsigned r;
        logic [1:0]  h;

        async_reset();

        // Reset asserted while running with remaining = 7
        apply(1, 7, 0, 0, 2'b00, 32'h0, 0);
        apply(0, 0, 1, 0, 2'b00, 32'h0, 0);
        check("rem7", 64'(remaining), 64'd7);
        #2;
        async_reset();
        check("rst_state", 64'(state), 64'd0);
        check("rst_rem",   64'(remaining), 64'd0);
        check("rst_irq",   64'(irq), 64'd0);

        // Expiry after three ticks
        apply(1, 3, 0, 0, 2'b00, 32'h0, 0);
        apply(0, 0, 1, 0, 2'b00, 32'h0, 0);
        apply(0, 0, 0, 1, 2'b00, 32'h40, 0);
        apply(0, 0, 0, 1, 2'b00, 32'h44, 0);
        check("exp_irq_early", 64'(irq), 64'd0);
        apply(0, 0, 0, 1, 2'b00, 32'h48, 0);
        check("exp_irq", 64'(irq), 64'd1);
        check("exp_pc",  64'(saved_pc), 64'h48);
        apply(0, 0, 0, 1, 2'b00, 32'h4c, 0);
        check("exp_irq_hold", 64'(irq), 64'd1);
        apply(0, 0, 0, 0, 2'b00, 32'h0, 1);
        check("ack_irq",   64'(irq), 64'd0);
        check("ack_state", 64'(state), 64'd0);

        // Stall gating with quantum 4
        apply(1, 4, 0, 0, 2'b00, 32'h0, 0);
        apply(0, 0, 1, 0, 2'b00, 32'h0, 0);
        for (int i = 0; i < 7; i++) begin
            apply(0, 0, 0, stall_pat[i] != 0, 2'b00, 32'h100 + 32'(i), 0);
            check("stall_rem", 64'(remaining), 64'(stall_rem[i]));
            check("stall_irq", 64'(irq), (i == 6) ? 64'd1 : 64'd0);
        end
        check("stall_pc", 64'(saved_pc), 64'h106);
        apply(0, 0, 0, 0, 2'b00, 32'h0, 1);

        // Process end takes priority over expiry
        apply(1, 2, 0, 0, 2'b00, 32'h0, 0);
        apply(0, 0, 1, 0, 2'b00, 32'h0, 0);
        apply(0, 0, 0, 1, 2'b00, 32'h50, 0);
        apply(0, 0, 0, 1, 2'b01, 32'h99, 0);
        check("hp_irq",   64'(irq), 64'd0);
        check("hp_done",  64'(proc_done), 64'd1);
        check("hp_state", 64'(state), 64'd0);
        check("hp_pc",    64'(saved_pc), 64'h106);
        apply(0, 0, 0, 0, 2'b00, 32'h0, 0);
        check("hp_done_pulse", 64'(proc_done), 64'd0);

        // Zero quantum disables preemption; reprogramming applies at re-dispatch
        apply(1, 0, 0, 0, 2'b00, 32'h0, 0);
        apply(0, 0, 1, 0, 2'b00, 32'h0, 0);
        for (int i = 0; i < 100; i++) apply(0, 0, 0, 1, 2'b00, 32'h200, 0);
        check("q0_irq",   64'(irq), 64'd0);
        check("q0_state", 64'(state), 64'd1);
        apply(1, 5, 0, 0, 2'b00, 32'h0, 0);
        check("q5_hold", 64'(remaining), 64'd0);
        apply(0, 0, 1, 0, 2'b00, 32'h0, 0);
        check("q5_load", 64'(remaining), 64'd5);

        // Machine halt during EXPIRE is terminal
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 2'b00, 32'h300 + 32'(i), 0);
        check("mh_irq_pre", 64'(irq), 64'd1);
        apply(0, 0, 0, 0, 2'b10, 32'h0, 0);
        check("mh_halted", 64'(halted), 64'd1);
        check("mh_irq",    64'(irq), 64'd0);
        check("mh_state",  64'(state), 64'd3);
        apply(0, 0, 0, 0, 2'b00, 32'h0, 1);
        apply(1, 9, 1, 1, 2'b01, 32'h0, 0);
        check("mh_stay", 64'(state), 64'd3);
        check("mh_pc",   64'(saved_pc), 64'h304);

        // Randomized traffic
        async_reset();
        for (int i = 0; i < 4000; i++) begin
            if ((m_mode == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
                #2;
                async_reset();
            end
            r = $urandom_range(0, 999);
            if (r < 3) h = 2'b10;
            else if (r < 40) h = 2'b01;
            else if (r < 50) h = 2'b11;
            else h = 2'b00;
            apply($urandom_range(0, 19) == 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 8),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7,
                  h,
                  $urandom,
                  $urandom_range(0, 9) < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
